// File: rtl/fifo_mem_sink.sv
// fifo_mem_sink: drains the interpolator output FIFO into the output memory.
// A start pulse latches depth/offset/mode and issues one FIFO read per cycle
// while data is available. Each read becomes a registered memory write one
// cycle later. The address mode is absolute, offset or append.
// Optional build macro SINK_TIMEOUT_EN bounds the time spent stalled on an empty
// FIFO. When the bound is reached the transfer ends in DONE with the timeout flag set.
module fifo_mem_sink #(
    parameter int DATA_WIDTH     = 32,
    parameter int ADDR_WIDTH     = 8,
    parameter int CNT_WIDTH      = 16,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic                  clk,
    input  logic                  rstn,
    input  logic                  start_i,
    input  logic                  empty_i,
    input  logic [127:0]          config_reg,
    input  logic [DATA_WIDTH-1:0] data_i,
    output logic                  RE_fifo_o,
    output logic                  WE_mem_o,
    output logic [ADDR_WIDTH-1:0] addr_mem_o,
    output logic [DATA_WIDTH-1:0] data_mem_o,
    output logic [7:0]            status_reg
);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_DRAIN = 2'd1;
    localparam logic [1:0] S_FLUSH = 2'd2;
    localparam logic [1:0] S_DONE  = 2'd3;

    localparam logic [1:0] M_OFFSET = 2'b01;
    localparam logic [1:0] M_APPEND = 2'b10;

    logic [1:0]            state_q, state_d;
    logic [CNT_WIDTH-1:0]  issue_cnt_q, issue_cnt_d;
    logic [CNT_WIDTH-1:0]  depth_q, depth_d;
    logic [ADDR_WIDTH-1:0] offset_q, offset_d;
    logic [1:0]            mode_q, mode_d;
    logic [ADDR_WIDTH-1:0] addr_save_q, addr_save_d;
    logic                  we_q;
    logic [ADDR_WIDTH-1:0] addr_q;

    logic re;
    logic stall;
    logic aborted;
    logic tmo_limit;
    logic timeout_flag;

    // Only depth, offset and mode are consumed from the config word.
    logic unused_cfg;
    assign unused_cfg = ^config_reg[127:34];

    // Write address of issue index k; every sum wraps at ADDR_WIDTH bits.
    function automatic logic [ADDR_WIDTH-1:0] issue_addr(
        input logic [1:0]            mode,
        input logic [ADDR_WIDTH-1:0] offset,
        input logic [ADDR_WIDTH-1:0] save,
        input logic [CNT_WIDTH-1:0]  k
    );
        logic [ADDR_WIDTH-1:0] k_w;
        k_w = ADDR_WIDTH'(k);
        case (mode)
            M_OFFSET: return offset + k_w;
            M_APPEND: return save + k_w;
            default:  return k_w;
        endcase
    endfunction

    // Transfer FSM: start/abort handling, read issue, stall detection, append bookkeeping.
    always_comb begin
        state_d     = state_q;
        issue_cnt_d = issue_cnt_q;
        depth_d     = depth_q;
        offset_d    = offset_q;
        mode_d      = mode_q;
        addr_save_d = addr_save_q;
        re          = 1'b0;
        stall       = 1'b0;
        aborted     = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (start_i) begin
                    depth_d     = CNT_WIDTH'(config_reg[15:0]);
                    offset_d    = ADDR_WIDTH'(config_reg[31:16]);
                    mode_d      = config_reg[33:32];
                    issue_cnt_d = '0;
                    state_d     = S_DRAIN;
                end
            end
            S_DRAIN: begin
                if (start_i) begin
                    aborted = 1'b1;
                    state_d = S_IDLE;
                end else if (issue_cnt_q == depth_q) begin
                    state_d = S_FLUSH;
                end else if (empty_i) begin
                    stall = 1'b1;
                    if (tmo_limit) begin
                        state_d = S_DONE;
                    end
                end else begin
                    re          = 1'b1;
                    issue_cnt_d = issue_cnt_q + CNT_WIDTH'(1);
                end
            end
            S_FLUSH: begin
                state_d = S_DONE;
            end
            default: begin
                state_d = S_IDLE;
                if (mode_q == M_APPEND && !timeout_flag) begin
                    addr_save_d = addr_save_q + ADDR_WIDTH'(issue_cnt_q);
                end
            end
        endcase
    end

    // State, latched config and the one-deep write pipeline.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q     <= S_IDLE;
            issue_cnt_q <= '0;
            depth_q     <= '0;
            offset_q    <= '0;
            mode_q      <= '0;
            addr_save_q <= '0;
            we_q        <= 1'b0;
            addr_q      <= '0;
        end else begin
            state_q     <= state_d;
            issue_cnt_q <= issue_cnt_d;
            depth_q     <= depth_d;
            offset_q    <= offset_d;
            mode_q      <= mode_d;
            addr_save_q <= addr_save_d;
            we_q        <= re;
            if (re) begin
                addr_q <= issue_addr(mode_q, offset_q, addr_save_q, issue_cnt_q);
            end
        end
    end

`ifdef SINK_TIMEOUT_EN
    localparam int STALL_W = $clog2(TIMEOUT_CYCLES + 1);

    logic [STALL_W-1:0] stall_cnt_q;
    logic               timeout_q;

    assign tmo_limit    = (stall_cnt_q == STALL_W'(TIMEOUT_CYCLES - 1));
    assign timeout_flag = timeout_q;

    // Consecutive-stall counter; a stall on the limit cycle forces DONE with timeout.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            stall_cnt_q <= '0;
            timeout_q   <= 1'b0;
        end else begin
            timeout_q <= stall & tmo_limit;
            if (state_q != S_DRAIN || re) begin
                stall_cnt_q <= '0;
            end else if (stall) begin
                stall_cnt_q <= stall_cnt_q + STALL_W'(1);
            end
        end
    end
`else
    localparam int unused_timeout_cycles = TIMEOUT_CYCLES;

    assign tmo_limit    = 1'b0;
    assign timeout_flag = 1'b0;
`endif

    assign RE_fifo_o  = re;
    assign WE_mem_o   = we_q;
    assign addr_mem_o = addr_q;
    assign data_mem_o = data_i;
    assign status_reg = {3'b000,
                         timeout_flag,
                         aborted,
                         stall,
                         (state_q == S_DRAIN) || (state_q == S_FLUSH),
                         (state_q == S_DONE)};

endmodule

// File: tb/tb_fifo_mem_sink.sv
// Bench for fifo_mem_sink: table of transfers with hand-derived address
// expectations, hand sequences for stall/abort/reset/timeout, then random
// transfers against a queue-style FIFO/memory model.
module tb_fifo_mem_sink;

    localparam int DW = 32;
    localparam int AW = 8;
`ifdef SINK_TIMEOUT_EN
    localparam int TMO = 16;
`else
    localparam int TMO = 1024;
`endif

    logic          clk = 1'b0;
    logic          rstn;
    logic          start_i;
    logic          empty_i;
    logic [127:0]  config_reg;
    logic [DW-1:0] data_i = '0;
    logic          RE_fifo_o;
    logic          WE_mem_o;
    logic [AW-1:0] addr_mem_o;
    logic [DW-1:0] data_mem_o;
    logic [7:0]    status_reg;

    fifo_mem_sink #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .CNT_WIDTH(16), .TIMEOUT_CYCLES(TMO)) dut (
        .clk(clk), .rstn(rstn), .start_i(start_i), .empty_i(empty_i),
        .config_reg(config_reg), .data_i(data_i), .RE_fifo_o(RE_fifo_o),
        .WE_mem_o(WE_mem_o), .addr_mem_o(addr_mem_o), .data_mem_o(data_mem_o),
        .status_reg(status_reg)
    );

    always #5 clk = ~clk;

    // FIFO model: contents written by the stimulus, popped on RE.
    logic [DW-1:0] fifo_mem [0:1023];
    int  wr_ptr = 0;
    int  rd_ptr = 0;
    logic force_empty;
    assign empty_i = force_empty | (rd_ptr == wr_ptr);

    always @(posedge clk) begin
        if (RE_fifo_o) begin
            data_i <= fifo_mem[rd_ptr % 1024];
            rd_ptr <= rd_ptr + 1;
        end
    end

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Monitor: memory write log and status event counters, sampled mid-cycle.
    logic [AW-1:0] wr_addr [0:1023];
    logic [DW-1:0] wr_data [0:1023];
    int wr_n = 0, re_n = 0, done_n = 0, busy_n = 0, stall_n = 0;
    int abort_n = 0, tmo_n = 0, bad_n = 0;
    int last_we_cyc = 0, done_cyc = 0, tmo_cyc = 0;

    always @(negedge clk) begin
        if (WE_mem_o) begin
            wr_addr[wr_n % 1024] <= addr_mem_o;
            wr_data[wr_n % 1024] <= data_mem_o;
            wr_n <= wr_n + 1;
            last_we_cyc <= cyc;
        end
        if (RE_fifo_o) re_n <= re_n + 1;
        if (status_reg[0]) begin done_n <= done_n + 1; done_cyc <= cyc; end
        if (status_reg[1]) busy_n <= busy_n + 1;
        if (status_reg[2]) stall_n <= stall_n + 1;
        if (status_reg[3]) abort_n <= abort_n + 1;
        if (status_reg[4]) begin tmo_n <= tmo_n + 1; tmo_cyc <= cyc; end
        if (RE_fifo_o && (empty_i || status_reg[2])) bad_n <= bad_n + 1;
    end

    int n_total = 0;
    int n_pass  = 0;
    logic [AW-1:0] model_save = '0;

    task automatic chk(input string name, input longint act, input longint exp);
        n_total++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic load_words(input int n);
        for (int i = 0; i < n; i++) begin
            fifo_mem[wr_ptr % 1024] = $urandom;
            wr_ptr++;
        end
    endtask

    task automatic start_xfer(input logic [1:0] mode, input logic [15:0] offset, input int depth);
        config_reg = {$urandom, $urandom, $urandom, $urandom};
        config_reg[15:0]  = depth[15:0];
        config_reg[31:16] = offset;
        config_reg[33:32] = mode;
        start_i = 1'b1;
        step();
        start_i = 1'b0;
        config_reg = {$urandom, $urandom, $urandom, $urandom};
    endtask

    // Full transfer checked against the model: address = base + k (wrapping), data in FIFO order.
    task automatic run_transfer(input logic [1:0] mode, input logic [15:0] offset, input int depth,
                                input int stall_after, input int stall_len, input int stall_pct,
                                output int n_wr, output logic [AW-1:0] first_a,
                                output logic [AW-1:0] last_a, output int n_stall);
        int base_rd, w0, d0, b0, s0, r0, bad0, st_cyc, budget, given;
        logic [AW-1:0] base;
        load_words(depth);
        base_rd = rd_ptr; w0 = wr_n; d0 = done_n; b0 = busy_n; s0 = stall_n; r0 = re_n; bad0 = bad_n;
        base = (mode == 2'b01) ? offset[AW-1:0] : (mode == 2'b10) ? model_save : '0;
        st_cyc = cyc;
        start_xfer(mode, offset, depth);
        budget = 0; given = 0;
        while (done_n == d0 && budget < 300) begin
            if (stall_after >= 0) begin
                if ((re_n - r0) == stall_after && given < stall_len) begin
                    force_empty = 1'b1;
                    given++;
                end else begin
                    force_empty = 1'b0;
                end
            end else begin
                force_empty = ($urandom_range(99) < stall_pct);
            end
            step();
            budget++;
        end
        force_empty = 1'b0;
        step(); step();
        chk("done_pulse", done_n - d0, 1);
        n_wr = wr_n - w0;
        n_stall = stall_n - s0;
        chk("n_writes", n_wr, depth);
        for (int k = 0; k < depth && k < n_wr; k++) begin
            chk("wr_addr", wr_addr[(w0 + k) % 1024], 64'(AW'(base + AW'(k))));
            chk("wr_data", wr_data[(w0 + k) % 1024], fifo_mem[(base_rd + k) % 1024]);
        end
        first_a = (n_wr > 0) ? wr_addr[w0 % 1024] : '0;
        last_a  = (n_wr > 0) ? wr_addr[(w0 + n_wr - 1) % 1024] : '0;
        chk("busy_cycles", busy_n - b0, depth + 2 + n_stall);
        chk("re_when_empty", bad_n - bad0, 0);
        if (depth > 0) chk("done_after_last_we", done_cyc - last_we_cyc, 2);
        else           chk("done_after_start", done_cyc - st_cyc, 3);
        if (mode == 2'b10) model_save = model_save + AW'(depth);
    endtask

    typedef struct {
        logic [1:0]    mode;
        logic [15:0]   offset;
        int            depth;
        int            stall_pct;
        int            exp_n;
        logic [AW-1:0] exp_first;
        logic [AW-1:0] exp_last;
    } vec_t;

    vec_t vecs [8];

    initial begin
        int n_wr, n_stall, r0, w0, d0, a0, b0, budget;
        logic [AW-1:0] fa, la;

        vecs[0] = '{2'b00, 16'h0000, 4, 0,  4, 8'h00, 8'h03};
        vecs[1] = '{2'b01, 16'h00FE, 4, 0,  4, 8'hFE, 8'h01};
        vecs[2] = '{2'b10, 16'h0077, 3, 0,  3, 8'h00, 8'h02};
        vecs[3] = '{2'b10, 16'h0000, 3, 0,  3, 8'h03, 8'h05};
        vecs[4] = '{2'b11, 16'h0055, 2, 25, 2, 8'h00, 8'h01};
        vecs[5] = '{2'b01, 16'h1234, 3, 25, 3, 8'h34, 8'h36};
        vecs[6] = '{2'b00, 16'h0000, 0, 0,  0, 8'h00, 8'h00};
        vecs[7] = '{2'b10, 16'h00AA, 2, 25, 2, 8'h06, 8'h07};

        rstn = 1'b0; start_i = 1'b0; force_empty = 1'b0; config_reg = '0;
        step(); step();
        chk("rst_re", RE_fifo_o, 0);
        chk("rst_we", WE_mem_o, 0);
        chk("rst_addr", addr_mem_o, 0);
        chk("rst_status", status_reg, 0);
        rstn = 1'b1;
        step();

        for (int i = 0; i < 8; i++) begin
            run_transfer(vecs[i].mode, vecs[i].offset, vecs[i].depth, -1, 0, vecs[i].stall_pct,
                         n_wr, fa, la, n_stall);
            chk("tbl_n", n_wr, vecs[i].exp_n);
            if (vecs[i].exp_n > 0) begin
                chk("tbl_first", fa, vecs[i].exp_first);
                chk("tbl_last", la, vecs[i].exp_last);
            end
        end

        // Stall: empty for 3 cycles after the 2nd read.
        run_transfer(2'b00, 16'h0, 5, 2, 3, 0, n_wr, fa, la, n_stall);
        chk("stall_cycles", n_stall, 3);

        // Abort after 2 reads of an 8-word transfer.
        load_words(8);
        r0 = re_n; w0 = wr_n; d0 = done_n; a0 = abort_n; b0 = rd_ptr;
        start_xfer(2'b00, 16'h0, 8);
        budget = 0;
        while ((re_n - r0) < 2 && budget < 20) begin step(); budget++; end
        start_i = 1'b1;
        step();
        start_i = 1'b0;
        repeat (4) step();
        chk("abort_pulse", abort_n - a0, 1);
        chk("abort_writes", wr_n - w0, 2);
        chk("abort_reads", re_n - r0, 2);
        chk("abort_no_done", done_n - d0, 0);
        chk("abort_idle", status_reg[1], 0);
        chk("abort_data1", wr_data[(w0 + 1) % 1024], fifo_mem[(b0 + 1) % 1024]);

        // Reset in the middle of a transfer.
        load_words(8);
        r0 = re_n; d0 = done_n;
        start_xfer(2'b01, 16'h0040, 8);
        budget = 0;
        while ((re_n - r0) < 2 && budget < 20) begin step(); budget++; end
        rstn = 1'b0;
        #1;
        chk("midrst_re", RE_fifo_o, 0);
        chk("midrst_we", WE_mem_o, 0);
        chk("midrst_addr", addr_mem_o, 0);
        chk("midrst_status", status_reg, 0);
        step(); step();
        rstn = 1'b1;
        model_save = '0;
        w0 = wr_n;
        repeat (6) step();
        chk("midrst_no_we", wr_n - w0, 0);
        chk("midrst_no_done", done_n - d0, 0);
        run_transfer(2'b10, 16'h0, 3, -1, 0, 0, n_wr, fa, la, n_stall);
        chk("append_after_rst", fa, 8'h00);

`ifdef SINK_TIMEOUT_EN
        // Timeout after 2 reads, then a follow-up append must reuse the old save address.
        load_words(4);
        r0 = re_n; w0 = wr_n; d0 = done_n; a0 = tmo_n; b0 = stall_n;
        start_xfer(2'b10, 16'h0, 4);
        budget = 0;
        while (done_n == d0 && budget < 60) begin
            force_empty = ((re_n - r0) >= 2);
            step();
            budget++;
        end
        force_empty = 1'b0;
        step();
        chk("tmo_pulse", tmo_n - a0, 1);
        chk("tmo_done", done_n - d0, 1);
        chk("tmo_with_done", tmo_cyc, done_cyc);
        chk("tmo_stalls", stall_n - b0, 16);
        chk("tmo_writes", wr_n - w0, 2);
        run_transfer(2'b10, 16'h0, 2, -1, 0, 0, n_wr, fa, la, n_stall);
        chk("tmo_save_kept", fa, 8'h03);
`endif

        for (int i = 0; i < 25; i++) begin
            run_transfer(2'($urandom_range(3)), 16'($urandom), $urandom_range(12), -1, 0, 30,
                         n_wr, fa, la, n_stall);
        end

`ifndef SINK_TIMEOUT_EN
        chk("no_timeout_flag", tmo_n, 0);
`endif

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
